// File: rtl/sig_check_engine.sv
// Run-and-check controller: holds the core in reset, runs it until halt or budget expiry,
// then streams the signature region of data memory against expected memory and reports.
module sig_check_engine #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DM_ADDR_W  = 8,
   parameter int unsigned EXP_ADDR_W = 8,
   parameter int unsigned SIG_BASE   = 'h40,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned MAX_CYCLES = 100,
   parameter bit          USE_HALT   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [EXP_ADDR_W:0]   sig_len,
   input  logic                  halt,
   output logic                  cpu_rst,
   output logic [DM_ADDR_W-1:0]  dm_rd_addr,
   input  logic [DATA_W-1:0]     dm_rd_data,
   output logic [EXP_ADDR_W-1:0] exp_rd_addr,
   input  logic [DATA_W-1:0]     exp_rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [EXP_ADDR_W:0]   err_cnt,
   output logic [EXP_ADDR_W-1:0] first_err_idx,
   output logic [DATA_W-1:0]     first_err_got,
   output logic [DATA_W-1:0]     first_err_exp
);

   localparam int unsigned LenW = EXP_ADDR_W + 1;
   localparam logic [LenW-1:0] MaxLen = {1'b1, {EXP_ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      StIdle,
      StHold,
      StRun,
      StRead,
      StDrain,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [LenW-1:0]       len_q, len_d;
   logic [LenW-1:0]       rd_cnt_q, rd_cnt_d;
   logic [EXP_ADDR_W-1:0] exp_addr_q, exp_addr_d;
   logic [DM_ADDR_W-1:0]  dm_addr_q, dm_addr_d;
   logic                  cmp_vld_q, cmp_vld_d;
   logic [EXP_ADDR_W-1:0] cmp_idx_q, cmp_idx_d;
   logic [LenW-1:0]       err_cnt_q, err_cnt_d;
   logic                  timeout_q, timeout_d;
   logic [EXP_ADDR_W-1:0] first_idx_q, first_idx_d;
   logic [DATA_W-1:0]     first_got_q, first_got_d;
   logic [DATA_W-1:0]     first_exp_q, first_exp_d;
   logic                  go_read;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      rd_cnt_d    = rd_cnt_q;
      exp_addr_d  = exp_addr_q;
      dm_addr_d   = dm_addr_q;
      err_cnt_d   = err_cnt_q;
      timeout_d   = timeout_q;
      first_idx_d = first_idx_q;
      first_got_d = first_got_q;
      first_exp_d = first_exp_q;
      go_read     = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               len_d       = (sig_len > MaxLen) ? MaxLen : sig_len;
               cnt_d       = '0;
               err_cnt_d   = '0;
               timeout_d   = 1'b0;
               first_idx_d = '0;
               first_got_d = '0;
               first_exp_d = '0;
               state_d     = StHold;
            end
         end
         StHold: begin
            if (cnt_q == 32'(RST_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StRun: begin
            // Halt takes priority over a coinciding budget expiry.
            if (USE_HALT && halt) begin
               go_read = 1'b1;
            end else if (cnt_q == 32'(MAX_CYCLES - 1)) begin
               go_read   = 1'b1;
               timeout_d = USE_HALT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
            if (go_read) begin
               state_d  = StRead;
               rd_cnt_d = '0;
               if (len_q != '0) begin
                  exp_addr_d = '0;
                  dm_addr_d  = DM_ADDR_W'(SIG_BASE);
               end
            end
         end
         StRead: begin
            if (len_q == '0) begin
               state_d = StDone;
            end else if (rd_cnt_q == (len_q - LenW'(1))) begin
               state_d = StDrain;
            end else begin
               rd_cnt_d   = rd_cnt_q + LenW'(1);
               exp_addr_d = exp_addr_q + EXP_ADDR_W'(1);
               dm_addr_d  = dm_addr_q + DM_ADDR_W'(1);
            end
         end
         StDrain: state_d = StDone;
         default: state_d = StIdle;
      endcase

      // Compare stage sees read data one cycle after the address was issued.
      cmp_vld_d = (state_q == StRead) && (len_q != '0);
      cmp_idx_d = exp_addr_q;
      if (cmp_vld_q && (dm_rd_data != exp_rd_data)) begin
         err_cnt_d = err_cnt_q + LenW'(1);
         if (err_cnt_q == '0) begin
            first_idx_d = cmp_idx_q;
            first_got_d = dm_rd_data;
            first_exp_d = exp_rd_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         len_q       <= '0;
         rd_cnt_q    <= '0;
         exp_addr_q  <= '0;
         dm_addr_q   <= '0;
         cmp_vld_q   <= 1'b0;
         cmp_idx_q   <= '0;
         err_cnt_q   <= '0;
         timeout_q   <= 1'b0;
         first_idx_q <= '0;
         first_got_q <= '0;
         first_exp_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         rd_cnt_q    <= rd_cnt_d;
         exp_addr_q  <= exp_addr_d;
         dm_addr_q   <= dm_addr_d;
         cmp_vld_q   <= cmp_vld_d;
         cmp_idx_q   <= cmp_idx_d;
         err_cnt_q   <= err_cnt_d;
         timeout_q   <= timeout_d;
         first_idx_q <= first_idx_d;
         first_got_q <= first_got_d;
         first_exp_q <= first_exp_d;
      end
   end

   assign cpu_rst       = (state_q != StRun);
   assign busy          = (state_q == StHold) || (state_q == StRun) ||
                          (state_q == StRead) || (state_q == StDrain);
   assign done          = (state_q == StDone);
   assign pass          = done && (err_cnt_q == '0) && !timeout_q;
   assign timeout       = timeout_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = first_idx_q;
   assign first_err_got = first_got_q;
   assign first_err_exp = first_exp_q;
   assign dm_rd_addr    = dm_addr_q;
   assign exp_rd_addr   = exp_addr_q;

endmodule

// File: tb/tb_sig_check_engine.sv
// Scoreboard bench for sig_check_engine: stimulus queues expected results, a monitor
// checks each result plus hold/run/read-phase timing and the read address sequence.
module tb_sig_check_engine;

   typedef struct {
      bit          pass;
      bit          to;
      int          err;
      int          fidx;
      logic [31:0] fgot;
      logic [31:0] fexp;
      int          run_cyc;
      int          len;
   } exp_t;

   logic        clk, rst;
   logic        start, halt;
   logic [8:0]  sig_len;
   logic        cpu_rst, busy, done, pass, timeout;
   logic [7:0]  dm_rd_addr, exp_rd_addr, first_err_idx;
   logic [31:0] dm_rd_data, exp_rd_data, first_err_got, first_err_exp;
   logic [8:0]  err_cnt;

   logic        start0, halt0;
   logic [8:0]  sig_len0;
   logic        cpu_rst0, busy0, done0, pass0, timeout0;
   logic [7:0]  dm_rd_addr0, exp_rd_addr0, first_err_idx0;
   logic [31:0] dm_rd_data0, exp_rd_data0, first_err_got0, first_err_exp0;
   logic [8:0]  err_cnt0;

   logic [31:0] dm   [256];
   logic [31:0] expm [256];

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   sig_check_engine dut (
      .clk(clk), .rst(rst), .start(start), .sig_len(sig_len), .halt(halt),
      .cpu_rst(cpu_rst), .dm_rd_addr(dm_rd_addr), .dm_rd_data(dm_rd_data),
      .exp_rd_addr(exp_rd_addr), .exp_rd_data(exp_rd_data), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .first_err_got(first_err_got), .first_err_exp(first_err_exp)
   );

   sig_check_engine #(.USE_HALT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .sig_len(sig_len0), .halt(halt0),
      .cpu_rst(cpu_rst0), .dm_rd_addr(dm_rd_addr0), .dm_rd_data(dm_rd_data0),
      .exp_rd_addr(exp_rd_addr0), .exp_rd_data(exp_rd_data0), .busy(busy0), .done(done0),
      .pass(pass0), .timeout(timeout0), .err_cnt(err_cnt0), .first_err_idx(first_err_idx0),
      .first_err_got(first_err_got0), .first_err_exp(first_err_exp0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      dm_rd_data   <= dm[dm_rd_addr];
      exp_rd_data  <= expm[exp_rd_addr];
      dm_rd_data0  <= dm[dm_rd_addr0];
      exp_rd_data0 <= expm[exp_rd_addr0];
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic push(input bit p, input bit to, input int err, input int fidx,
                       input logic [31:0] fgot, input logic [31:0] fexp,
                       input int run_cyc, input int len);
      exp_t e;
      e.pass = p; e.to = to; e.err = err; e.fidx = fidx; e.fgot = fgot; e.fexp = fexp;
      e.run_cyc = run_cyc; e.len = len;
      sb.push_back(e);
   endtask

   task automatic wait_run();
      int k;
      for (k = 0; k < 20 && cpu_rst; k++) @(negedge clk);
      if (cpu_rst) begin
         n_tests++; n_fail++;
         $display("FAIL wait_run: cpu_rst still %0b after %0d cycles", cpu_rst, k);
      end
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 600 && !done; k++) @(negedge clk);
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL wait_done: done still %0b after %0d cycles", done, k);
      end
   endtask

   // Called at a negedge; stray=1 pulses start during RUN and READ (needs halt_after>=3).
   task automatic do_run(input int len, input int halt_after, input bit stray);
      sig_len = 9'(len);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_done_clr", done, 0);
      if (halt_after > 0) begin
         wait_run();
         for (int c = 1; c < halt_after; c++) begin
            if (stray && c == 2) begin start = 1'b1; sig_len = 9'd2; end
            else begin start = 1'b0; sig_len = 9'(len); end
            @(negedge clk);
         end
         start   = 1'b0;
         sig_len = 9'(len);
         halt    = 1'b1;
         @(negedge clk);
         halt = 1'b0;
         if (stray) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      wait_done();
   endtask

   // Monitor: phase counters per run, compare on rising done.
   initial begin
      int   hold_c, run_c, post_c, addr_bad;
      bit   seen_run, prev_done;
      exp_t e;
      hold_c = 0; run_c = 0; post_c = 0; addr_bad = 0; seen_run = 0; prev_done = 0;
      forever begin
         @(negedge clk);
         if (done && !prev_done) begin
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_result: got done=%0b expected no result", done);
            end else begin
               e = sb.pop_front();
               check("pass", pass, e.pass);
               check("timeout", timeout, e.to);
               check("err_cnt", err_cnt, e.err);
               check("first_err_idx", first_err_idx, e.fidx);
               check("first_err_got", first_err_got, e.fgot);
               check("first_err_exp", first_err_exp, e.fexp);
               check("hold_cycles", hold_c, 2);
               check("run_cycles", run_c, e.run_cyc);
               check("read_drain_cycles", post_c, (e.len == 0) ? 1 : e.len + 1);
               check("addr_seq_bad", addr_bad, 0);
            end
         end
         prev_done = done;
         if (!busy) begin
            hold_c = 0; run_c = 0; post_c = 0; addr_bad = 0; seen_run = 0;
         end else if (!cpu_rst) begin
            run_c++;
            seen_run = 1;
         end else if (!seen_run) begin
            hold_c++;
         end else begin
            if (sb.size() > 0 && post_c < sb[0].len) begin
               if (dm_rd_addr !== 8'(64 + post_c) || exp_rd_addr !== 8'(post_c)) addr_bad++;
            end
            post_c++;
         end
      end
   end

   initial begin
      int run0;
      for (int i = 0; i < 256; i++) begin
         expm[i]             = 32'(2 * i + 1);
         dm[(64 + i) % 256]  = 32'(2 * i + 1);
      end
      rst = 1'b1; start = 1'b0; halt = 1'b0; sig_len = '0;
      start0 = 1'b0; halt0 = 1'b1; sig_len0 = 9'd4;
      #12;
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_dm_addr", dm_rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // All match
      push(1, 0, 0, 0, 0, 0, 10, 4);
      do_run(4, 10, 0);
      // Single mismatch
      dm['h42] = 32'hDEADBEEF;
      push(0, 0, 1, 2, 32'hDEADBEEF, 32'h5, 10, 4);
      do_run(4, 10, 0);
      // Second mismatch must not move the first-error capture
      dm['h43] = 32'h0;
      push(0, 0, 2, 2, 32'hDEADBEEF, 32'h5, 7, 4);
      do_run(4, 7, 0);
      dm['h42] = 32'h5;
      dm['h43] = 32'h7;
      // Timeout with matching data
      push(0, 1, 0, 0, 0, 0, 100, 4);
      do_run(4, 0, 0);
      // Zero length
      push(1, 0, 0, 0, 0, 0, 5, 0);
      do_run(0, 5, 0);
      // Clamp 300 -> 256 with a mismatch placed where the address has wrapped to 0
      dm['h00] = 32'hFFFF0000;
      push(0, 0, 1, 192, 32'hFFFF0000, 32'h181, 3, 256);
      do_run(300, 3, 0);
      dm['h00] = 32'h181;

      // Reset during index 3 of 8
      sig_len = 9'd8;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_run();
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      repeat (3) @(negedge clk);
      check("midread_addr", dm_rd_addr, 'h43);
      #1 rst = 1'b1;
      #1;
      check("arst_cpu_rst", cpu_rst, 1);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_err_cnt", err_cnt, 0);
      check("arst_dm_addr", dm_rd_addr, 0);
      check("arst_exp_addr", exp_rd_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push(1, 0, 0, 0, 0, 0, 4, 8);
      do_run(8, 4, 0);

      // Start while busy ignored, then re-arm from DONE
      push(1, 0, 0, 0, 0, 0, 6, 4);
      do_run(4, 6, 1);
      push(1, 0, 0, 0, 0, 0, 2, 6);
      do_run(6, 2, 0);

      // USE_HALT=0: halt held high is ignored, full budget, no timeout
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      run0 = 0;
      for (int k = 0; k < 400 && !done0; k++) begin
         if (!cpu_rst0) run0++;
         @(negedge clk);
      end
      check("nohalt_done", done0, 1);
      check("nohalt_run_cycles", run0, 100);
      check("nohalt_timeout", timeout0, 0);
      check("nohalt_pass", pass0, 1);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
